// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: register function
// selects and the fetch state encoding.
package fetch_pkg;

    localparam logic [1:0] FS_CLEAR = 2'b00;
    localparam logic [1:0] FS_LOAD  = 2'b01;
    localparam logic [1:0] FS_DEC   = 2'b10;
    localparam logic [1:0] FS_INC   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        VALID,
        ERROR
    } fetch_state_e;

endpackage

// File: rtl/wait_timer.sv
// Counts memory wait cycles within one fetch state and flags when the
// allowed number of empty cycles has been used up.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // The final empty cycle is the one seen while the count already sits at LAST.
    assign expired = tick && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// Two-byte instruction fetch sequencer: reads low then high byte into the IR,
// bumps the PC per byte, and hands the word to decode over valid/ready.
module ir_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             flush,
    output logic             mem_req,
    input  logic             mem_rvalid,
    input  logic [7:0]       mem_rdata,
    output logic             pc_enable,
    output logic [1:0]       pc_funsel,
    output logic             ir_enable,
    output logic [1:0]       ir_funsel,
    output logic             ir_lh,
    output logic [7:0]       ir_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [CNT_W-1:0] fetch_count_q;
    logic [CNT_W-1:0] fetch_count_d;
    logic             in_fetch;
    logic             timer_clear;
    logic             timer_tick;
    logic             timer_expired;

    assign in_fetch    = (state_q == FETCH_LO) || (state_q == FETCH_HI);
    // Any byte arrival moves to a new state, so it restarts the wait budget.
    assign timer_clear = !in_fetch || mem_rvalid || flush;
    assign timer_tick  = in_fetch && !mem_rvalid;

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .tick   (timer_tick),
        .expired(timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        fetch_count_d = fetch_count_q;
        pc_enable     = 1'b0;
        pc_funsel     = FS_CLEAR;
        ir_enable     = 1'b0;
        ir_funsel     = FS_CLEAR;
        ir_lh         = 1'b0;

        if (flush) begin
            ir_enable = 1'b1;
            ir_funsel = FS_CLEAR;
            state_d   = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !halt) begin
                        state_d = FETCH_LO;
                    end
                end
                FETCH_LO, FETCH_HI: begin
                    if (mem_rvalid) begin
                        ir_enable = 1'b1;
                        ir_funsel = FS_LOAD;
                        ir_lh     = (state_q == FETCH_HI);
                        pc_enable = 1'b1;
                        pc_funsel = FS_INC;
                        state_d   = (state_q == FETCH_LO) ? FETCH_HI : VALID;
                    end else if (timer_expired) begin
                        state_d = ERROR;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                        state_d       = halt ? IDLE : FETCH_LO;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign ir_data     = mem_rdata;
    assign mem_req     = in_fetch;
    assign instr_valid = (state_q == VALID);
    assign busy        = (state_q != IDLE);
    assign timeout_err = (state_q == ERROR);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed bench for ir_fetch_ctrl: a vector table for the basic fetch flow,
// then hand-written sequences for waits, timeout, flush, reset and count wrap.
module tb_ir_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, flush, mem_rvalid, instr_ready;
    logic [7:0]  mem_rdata;
    logic        mem_req, pc_enable, ir_enable, ir_lh, instr_valid, busy, timeout_err;
    logic [1:0]  pc_funsel, ir_funsel;
    logic [7:0]  ir_data;
    logic [15:0] fetch_count;

    logic        mem_req2, pc_enable2, ir_enable2, ir_lh2, instr_valid2, busy2, timeout_err2;
    logic [1:0]  pc_funsel2, ir_funsel2;
    logic [7:0]  ir_data2;
    logic [1:0]  fetch_count2;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [15:0] irModel = '0;
    logic [15:0] pcModel = '0;

    always #5 clk = ~clk;

    ir_fetch_ctrl #(.TIMEOUT_CYCLES(15), .TO_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .flush(flush),
        .mem_req(mem_req), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pc_enable(pc_enable), .pc_funsel(pc_funsel), .ir_enable(ir_enable),
        .ir_funsel(ir_funsel), .ir_lh(ir_lh), .ir_data(ir_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
        .timeout_err(timeout_err), .fetch_count(fetch_count)
    );

    // Narrow-counter copy sharing every input, used to see the count wrap.
    ir_fetch_ctrl #(.TIMEOUT_CYCLES(15), .TO_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .flush(flush),
        .mem_req(mem_req2), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pc_enable(pc_enable2), .pc_funsel(pc_funsel2), .ir_enable(ir_enable2),
        .ir_funsel(ir_funsel2), .ir_lh(ir_lh2), .ir_data(ir_data2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready), .busy(busy2),
        .timeout_err(timeout_err2), .fetch_count(fetch_count2)
    );

    // Stand-ins for the external PC and IR registers driven by the strobes.
    always @(posedge clk) begin
        if (pc_enable) begin
            case (pc_funsel)
                2'b00: pcModel <= '0;
                2'b10: pcModel <= pcModel - 16'd1;
                2'b11: pcModel <= pcModel + 16'd1;
                default: pcModel <= pcModel;
            endcase
        end
        if (ir_enable) begin
            case (ir_funsel)
                2'b00: irModel <= '0;
                2'b01: if (ir_lh) irModel[15:8] <= ir_data; else irModel[7:0] <= ir_data;
                2'b10: irModel <= irModel - 16'd1;
                default: irModel <= irModel + 16'd1;
            endcase
        end
    end

    localparam logic [3:0] M_IDLE  = 4'b0010 & 4'b0000;
    localparam logic [3:0] M_FETCH = 4'b1010;
    localparam logic [3:0] M_VALID = 4'b0110;
    localparam logic [3:0] M_ERROR = 4'b0011;
    localparam logic [6:0] S_NONE  = 7'b0_00_0_00_0;
    localparam logic [6:0] S_LO    = 7'b1_11_1_01_0;
    localparam logic [6:0] S_HI    = 7'b1_11_1_01_1;
    localparam logic [6:0] S_FLUSH = 7'b0_00_1_00_0;

    typedef struct {
        logic       start, halt, flush, rvalid;
        logic [7:0] rdata;
        logic       ready;
        logic [3:0] expMoore;
        logic [6:0] expStrobe;
        logic [15:0] expIr, expPc, expCnt;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [3:0] moore();
        return {mem_req, instr_valid, busy, timeout_err};
    endfunction

    function automatic logic [6:0] strobes();
        return {pc_enable, pc_funsel, ir_enable, ir_funsel, ir_lh};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic f,
                                 input logic rv, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        start = s; halt = h; flush = f; mem_rvalid = rv; mem_rdata = d; instr_ready = rdy;
        #1;
    endtask

    task automatic doFetch(input logic [7:0] lo, input logic [7:0] hi);
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 1, lo, 0);
        applyStimulus(0, 0, 0, 1, hi, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
    endtask

    initial begin
        int n;

        vecs[0]  = '{1,0,0,0,8'h00,0, M_IDLE,  S_NONE,  16'h0000, 16'd0, 16'd0};
        vecs[1]  = '{0,0,0,1,8'h34,0, M_FETCH, S_LO,    16'h0000, 16'd0, 16'd0};
        vecs[2]  = '{0,0,0,1,8'h12,0, M_FETCH, S_HI,    16'h0034, 16'd1, 16'd0};
        vecs[3]  = '{0,0,0,0,8'h00,1, M_VALID, S_NONE,  16'h1234, 16'd2, 16'd0};
        vecs[4]  = '{0,0,0,0,8'h00,1, M_FETCH, S_NONE,  16'h1234, 16'd2, 16'd1};
        vecs[5]  = '{0,0,0,1,8'h78,1, M_FETCH, S_LO,    16'h1234, 16'd2, 16'd1};
        vecs[6]  = '{0,0,0,1,8'h56,1, M_FETCH, S_HI,    16'h1278, 16'd3, 16'd1};
        vecs[7]  = '{0,0,0,0,8'h00,0, M_VALID, S_NONE,  16'h5678, 16'd4, 16'd1};
        vecs[8]  = '{0,1,0,0,8'h00,1, M_VALID, S_NONE,  16'h5678, 16'd4, 16'd1};
        vecs[9]  = '{1,1,0,0,8'h00,0, M_IDLE,  S_NONE,  16'h5678, 16'd4, 16'd2};
        vecs[10] = '{0,0,0,1,8'h99,0, M_IDLE,  S_NONE,  16'h5678, 16'd4, 16'd2};
        vecs[11] = '{0,0,1,0,8'h00,0, M_IDLE,  S_FLUSH, 16'h5678, 16'd4, 16'd2};
        vecs[12] = '{0,0,0,0,8'h00,0, M_IDLE,  S_NONE,  16'h0000, 16'd4, 16'd2};

        rst = 1'b1;
        start = 0; halt = 0; flush = 0; mem_rvalid = 0; mem_rdata = 8'h00; instr_ready = 0;
        #3;
        checkOutput("reset_moore", 32'(moore()), 32'(M_IDLE));
        checkOutput("reset_strobes", 32'(strobes()), 32'(S_NONE));
        checkOutput("reset_count", 32'(fetch_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].start, vecs[i].halt, vecs[i].flush,
                          vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
            checkOutput($sformatf("vec%0d_moore", i), 32'(moore()), 32'(vecs[i].expMoore));
            checkOutput($sformatf("vec%0d_strobe", i), 32'(strobes()), 32'(vecs[i].expStrobe));
            checkOutput($sformatf("vec%0d_ir", i), 32'(irModel), 32'(vecs[i].expIr));
            checkOutput($sformatf("vec%0d_pc", i), 32'(pcModel), 32'(vecs[i].expPc));
            checkOutput($sformatf("vec%0d_cnt", i), 32'(fetch_count), 32'(vecs[i].expCnt));
            checkOutput($sformatf("vec%0d_irdata", i), 32'(ir_data), 32'(vecs[i].rdata));
        end
        checkOutput("narrow_cnt_2", 32'(fetch_count2), 32'd2);

        // Wait states on both bytes, then a five-cycle decode stall.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 0);
            checkOutput($sformatf("waitlo%0d_strobe", k), 32'(strobes()), 32'(S_NONE));
        end
        applyStimulus(0, 0, 0, 1, 8'hAB, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 0);
            checkOutput($sformatf("waithi%0d_moore", k), 32'(moore()), 32'(M_FETCH));
        end
        applyStimulus(0, 0, 0, 1, 8'hCD, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 0);
            checkOutput($sformatf("stall%0d_moore", k), 32'(moore()), 32'(M_VALID));
            checkOutput($sformatf("stall%0d_strobe", k), 32'(strobes()), 32'(S_NONE));
        end
        checkOutput("stall_ir", 32'(irModel), 32'h0000CDAB);
        checkOutput("stall_pc", 32'(pcModel), 32'd6);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        checkOutput("halt_moore", 32'(moore()), 32'(M_IDLE));
        checkOutput("stall_cnt", 32'(fetch_count), 32'd3);

        // Timeout while waiting for the high byte.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 1, 8'hEF, 0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 0);
            if (timeout_err) break;
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'd15);
        checkOutput("timeout_moore", 32'(moore()), 32'(M_ERROR));
        applyStimulus(1, 0, 0, 1, 8'h55, 0);
        checkOutput("error_sticky", 32'(moore()), 32'(M_ERROR));
        checkOutput("error_nostrobe", 32'(strobes()), 32'(S_NONE));
        applyStimulus(0, 0, 1, 0, 8'h00, 0);
        checkOutput("err_flush_strobe", 32'(strobes()), 32'(S_FLUSH));
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        checkOutput("err_flush_moore", 32'(moore()), 32'(M_IDLE));
        checkOutput("err_flush_ir", 32'(irModel), 32'd0);
        checkOutput("err_flush_pc", 32'(pcModel), 32'd7);

        // Flush colliding with a byte arrival.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 1, 1, 8'hAA, 0);
        checkOutput("flushrv_strobe", 32'(strobes()), 32'(S_FLUSH));
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        checkOutput("flushrv_moore", 32'(moore()), 32'(M_IDLE));
        checkOutput("flushrv_pc", 32'(pcModel), 32'd7);
        checkOutput("flushrv_ir", 32'(irModel), 32'd0);

        // Flush colliding with a handoff.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 1, 8'h11, 0);
        applyStimulus(0, 0, 0, 1, 8'h22, 0);
        applyStimulus(0, 0, 1, 0, 8'h00, 1);
        checkOutput("flushho_strobe", 32'(strobes()), 32'(S_FLUSH));
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        checkOutput("flushho_moore", 32'(moore()), 32'(M_IDLE));
        checkOutput("flushho_cnt", 32'(fetch_count), 32'd3);
        checkOutput("flushho_ir", 32'(irModel), 32'd0);
        checkOutput("flushho_pc", 32'(pcModel), 32'd9);

        // Asynchronous reset while in FETCH_HI with a byte on the bus.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 1, 8'h33, 0);
        applyStimulus(0, 0, 0, 1, 8'h44, 0);
        checkOutput("prerst_strobe", 32'(strobes()), 32'(S_HI));
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_moore", 32'(moore()), 32'(M_IDLE));
        checkOutput("rst_strobe", 32'(strobes()), 32'(S_NONE));
        checkOutput("rst_cnt", 32'(fetch_count), 32'd0);
        checkOutput("rst_cnt2", 32'(fetch_count2), 32'd0);
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        rst = 1'b0;
        checkOutput("rst_pc", 32'(pcModel), 32'd10);

        // Four handoffs wrap the 2-bit counter back to zero.
        for (int k = 0; k < 4; k++) begin
            doFetch(8'(k), 8'hC0);
            if (k == 2) begin
                applyStimulus(0, 0, 0, 0, 8'h00, 0);
                checkOutput("wrap_cnt2_3", 32'(fetch_count2), 32'd3);
            end
        end
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        checkOutput("wrap_cnt", 32'(fetch_count), 32'd4);
        checkOutput("wrap_cnt2", 32'(fetch_count2), 32'd0);
        checkOutput("wrap_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/ir_fetch_ctrl.md
# ir_fetch_ctrl

Instruction-fetch sequencer that drives the program-counter `register` instance and the `ir` instruction register. It requests two bytes from byte-wide memory: low byte first, then high byte. It loads them into `ir` through its `lh` half-select and increments the PC after each byte. It then offers the assembled 16-bit instruction to the decode stage over a valid/ready handshake. It sits between memory, the PC/IR storage and the decoder, and is the only block that writes PC increment and IR load strobes during fetch.

## Interface
- `TIMEOUT_CYCLES`, 15: maximum wait cycles for `mem_rvalid` per byte, valid range 1 to 2^TO_W-1.
- `TO_W`, 4: width of the wait counter.
- `CNT_W`, 16: width of the fetched-instruction counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin fetching; sampled only in IDLE.
- `halt`  in  1  stop after the current handoff; sampled in IDLE and at handoff.
- `flush`  in  1  abort fetch, clear IR, return to IDLE.
- `mem_req`  out  1  byte read request.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  8  read data.
- `pc_enable`  out  1  PC register enable.
- `pc_funsel`  out  2  PC register function select.
- `ir_enable`  out  1  IR enable.
- `ir_funsel`  out  2  IR function select.
- `ir_lh`  out  1  IR half select: 0 = bits [7:0], 1 = bits [15:8].
- `ir_data`  out  8  IR load data, equal to `mem_rdata`.
- `instr_valid`  out  1  IR holds a complete instruction.
- `instr_ready`  in  1  decoder accepts the instruction.
- `busy`  out  1  state is not IDLE.
- `timeout_err`  out  1  sticky fetch-timeout flag.
- `fetch_count`  out  CNT_W  number of instructions handed off.

## Operation
- Function-select encoding: 00 clear, 01 load, 10 decrement, 11 increment.
- States: IDLE, FETCH_LO, FETCH_HI, VALID, ERROR.
- IDLE:
  - `start`=1 and `halt`=0 → FETCH_LO.
  - `start` in any other state is ignored.
- FETCH_LO / FETCH_HI: `mem_req`=1.
  - In a cycle with `mem_rvalid`=1:
    - `ir_enable`=1, `ir_funsel`=01, `ir_lh`=0 in FETCH_LO and 1 in FETCH_HI.
    - `pc_enable`=1, `pc_funsel`=11.
  - Transitions: FETCH_LO→FETCH_HI, FETCH_HI→VALID.
- VALID: `instr_valid`=1, `mem_req`=0.
  - `instr_ready`=1 counts as a handoff: `fetch_count`+1, wrapping modulo 2^CNT_W.
  - On handoff, the next state is IDLE if `halt`=1, else FETCH_LO.
- Timeout:
  - The wait counter clears on entry to each FETCH state.
  - It counts each cycle in which `mem_rvalid`=0.
  - When the counter reaches `TIMEOUT_CYCLES` with no `mem_rvalid` → ERROR.
  - ERROR sets `timeout_err`=1, `mem_req`=0, and drives no strobes.
  - ERROR is left only via `flush` or `rst`.
- `flush` has priority over everything except `rst`:
  - That cycle: `ir_enable`=1, `ir_funsel`=00, no PC strobe, no `fetch_count` change.
  - Next state is IDLE, and `timeout_err` clears.
  - A coincident `mem_rvalid` byte is dropped.
  - A coincident handoff is not counted.
- Strobes are driven low whenever not asserted, with `pc_funsel` and `ir_funsel` at 00 in that case.

## Timing
- Reset values: state IDLE, all outputs 0, `fetch_count`=0, wait counter 0. `ir_data` follows `mem_rdata` at all times.
- Strobe outputs are Mealy: combinational from the state and `mem_rvalid`/`flush`.
- `mem_req`, `instr_valid`, `busy` and `timeout_err` are Moore (registered state).
- Minimum latency:
  - `start` high at edge 0 → FETCH_LO in cycle 1.
  - With `mem_rvalid` in cycles 1 and 2, `instr_valid` is high in cycle 3 and the IR holds the full word.
- Back-to-back throughput is 3 cycles per instruction with zero wait states.
- `instr_valid` stays high until handoff. Stalling `instr_ready` never alters the IR or PC.
- `rst` mid-fetch:
  - Immediate IDLE.
  - The PC and IR are not touched by this block. Their own reset is the integrator's concern.

## Structure
- Shared package `fetch_pkg` holds:
  - the function-select constants FS_CLEAR, FS_LOAD, FS_DEC, FS_INC;
  - the state enum.
- Sub-module `wait_timer`, parameters `TIMEOUT_CYCLES` and `TO_W`:
  - inputs `clear` and `tick`;
  - output `expired`.
- The FSM, handoff counter and strobe decode stay in `ir_fetch_ctrl`.

## Test plan
- Zero wait states:
  - Stimulus: `start`; `mem_rdata`=0x34 then 0x12; `instr_ready` tied to 1.
  - Response: IR=0x1234, `instr_valid` in cycle 3, PC incremented twice, `fetch_count`=1, the next FETCH_LO in cycle 4.
- Wait states and stall:
  - Stimulus: 3 idle cycles before each `mem_rvalid`; `instr_ready` held low for 5 cycles.
  - Response: `instr_valid` stays high, no extra strobes, `fetch_count` increments once.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=15, no `mem_rvalid` in FETCH_HI.
  - Response: ERROR after 15 cycles, `timeout_err`=1, `mem_req`=0.
  - Then `flush`: IDLE, flag cleared, IR cleared.
- Flush collisions:
  - Stimulus: `flush` together with `mem_rvalid`; separately, `flush` together with handoff.
  - Response: no PC increment, IR cleared, `fetch_count` unchanged, IDLE.
- Halt and reset:
  - Stimulus: `halt`=1 at handoff; separately, `rst` asserted in FETCH_HI.
  - Response: halt returns to IDLE with `busy`=0. Reset forces all outputs to 0 with no clock edge. `fetch_count` wrap checked with `CNT_W`=2 after 4 handoffs → 0.
